quant_unpack: RTL and testbench
===============================

Name: quant_unpack

Overview:
Receive-side counterpart of the 2-bit sample quantizer. Accepts 32-bit words, each packing 16 two-bit quantized samples, over a valid/ready handshake. Serializes them into one decoded signed sample per accepted output beat, for correlator and bench consumers of the firehose sample stream. Optionally accumulates per-window level statistics (outer-level rate, sign balance) to feed the future AGC/offset loop.

Parameters:
MAG_LO, 1, output magnitude for inner codes (00, 11); 7-bit unsigned, must be less than MAG_HI
MAG_HI, 3, output magnitude for outer codes (01, 10); 7-bit unsigned
WIN_LOG2, 16, statistics window length is 2^WIN_LOG2 accepted samples; legal range 4..24

Ports:
clk  in  1  sample clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  32  packed word; sample k occupies bits [2k+1:2k], with sample 0 emitted first
in_valid  in  1  in_data valid
in_ready  out  1  word accepted when in_valid && in_ready
y_code  out  2  raw 2-bit code of the current sample
y_val  out  8  decoded two's-complement sample
y_valid  out  1  y_code/y_val valid
y_ready  in  1  sample accepted when y_valid && y_ready
stat_outer  out  WIN_LOG2+1  count of outer codes in the last completed window
stat_pos  out  WIN_LOG2+1  count of positive codes (01, 00) in the last completed window
stat_valid  out  1  one-cycle pulse when stat_* update

Behaviour:
- Code map: 01 -> +MAG_HI, 00 -> +MAG_LO, 11 -> -MAG_LO, 10 -> -MAG_HI.
- State: 32-bit shift register sh, 4-bit index idx, flag full.
- y_valid = full; y_code = sh[1:0]; y_val = decode(sh[1:0]).
- y_* are driven only from registers. There is no combinational path from in_* to y_*.
- in_ready = !full || (y_ready && idx==15). This is the only combinational path from y_ready to in_ready.
- Word accept with buffer empty: sh <= in_data, idx <= 0, full <= 1. The first sample is visible on y_* the next cycle.
- Sample accept with idx<15: sh <= sh>>2, idx <= idx+1.
- Sample accept with idx==15:
  - If in_valid is high, load the new word (sh <= in_data, idx <= 0) with no bubble. Sustained throughput is 1 sample per clk.
  - Otherwise full <= 0.
- y_valid high and y_ready low: sh, idx and the y_* outputs hold stable indefinitely. No sample is lost or duplicated.
- in_valid while full and not at the last-sample accept: word is not taken (in_ready low). The upstream holds it.
- Reset (async assert, any time, including mid-word): full=0, idx=0, sh=0, y_valid=0, y_code=00, y_val=0, all stat_* = 0, window counters = 0. A partially consumed word is discarded. The first word after reset starts at sample 0.
- Reset release is synchronous to clk through the normal flop path; no output glitches high on deassertion.

Optional Feature:
Macro QUANT_UNPACK_STATS_EN.

Defined:
- Counters: wcnt (WIN_LOG2 bits), ocnt and pcnt (WIN_LOG2+1 bits).
- On each sample accept: wcnt increments; ocnt increments if the code is 01 or 10; pcnt increments if the code is 01 or 00.
- On the accept that wraps wcnt to 0 (2^WIN_LOG2 samples):
  - stat_outer <= ocnt plus the current sample's contribution, and stat_pos <= pcnt plus the current sample's contribution.
  - stat_valid pulses high the following cycle, for one cycle.
  - ocnt and pcnt restart from 0.
- No statistics change on cycles without an accept.

Not defined:
- stat_outer = 0, stat_pos = 0, stat_valid = 0 constantly.
- No counter logic is synthesized. Ports remain present.

Test Plan:
1. Word 0x00000000, y_ready=1 -> 16 consecutive y_valid beats, y_code=00, y_val=0x01. in_ready high during beat 16, then y_valid=0.
2. Word 0xE4E4E4E4 -> y_val sequence +1,+3,-3,-1 repeated 4x (0x01,0x03,0xFD,0xFF). y_code sequence 00,01,10,11.
3. Two back-to-back words with in_valid=1 and y_ready=1 -> 32 samples in 32 consecutive cycles with no gap. Second word's sample 0 follows first word's sample 15 directly.
4. Word 0xE4E4E4E4 with y_ready toggling 1,0,0,1,... -> y_val held stable while y_ready=0. Exactly 16 distinct accepts in order; in_ready low until the last accept.
5. STATS_EN defined, WIN_LOG2=4:
   - One word 0x55555555 -> stat_outer=16, stat_pos=16, stat_valid pulse 1 cycle after the 16th accept.
   - Then word 0xFFFFFFFF -> stat_outer=0, stat_pos=0.
6. rst_n pulsed low after 5 accepts of 0xE4E4E4E4 -> y_valid=0 and in_ready=1 immediately. stat_* = 0. The next word 0x00000001 first emits y_code=01 (y_val=0x03).

Source files
------------

// File: rtl/quant_unpack_if.sv
// ---------------------------------------------------------------------------
// quant_unpack_if
// Bundles the word input handshake, the decoded sample output handshake and
// the level-statistics outputs of quant_unpack.
//
// Parameters:
//   WIN_LOG2   - log2 of the statistics window; sets the stat_* widths
//
// Signals:
//   in_data    [31:0]       packed word, sample k in bits [2k+1:2k]
//   in_valid                in_data valid
//   in_ready                word accepted when in_valid && in_ready
//   y_code     [1:0]        raw code of the current sample
//   y_val      [7:0]        decoded two's-complement sample
//   y_valid                 y_code/y_val valid
//   y_ready                 sample accepted when y_valid && y_ready
//   stat_outer [WIN_LOG2:0] outer-code count of the last completed window
//   stat_pos   [WIN_LOG2:0] positive-code count of the last completed window
//   stat_valid              one-cycle pulse when stat_* update
//
// Modports:
//   master - the environment: drives words and y_ready
//   slave  - the unpacker itself
// ---------------------------------------------------------------------------
interface quant_unpack_if #(
    parameter int WIN_LOG2 = 16
);
    logic [31:0]       in_data;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        y_code;
    logic [7:0]        y_val;
    logic              y_valid;
    logic              y_ready;
    logic [WIN_LOG2:0] stat_outer;
    logic [WIN_LOG2:0] stat_pos;
    logic              stat_valid;

    modport master (
        output in_data, in_valid, y_ready,
        input  in_ready, y_code, y_val, y_valid,
        input  stat_outer, stat_pos, stat_valid
    );

    modport slave (
        input  in_data, in_valid, y_ready,
        output in_ready, y_code, y_val, y_valid,
        output stat_outer, stat_pos, stat_valid
    );
endinterface

// File: rtl/quant_unpack.sv
// ---------------------------------------------------------------------------
// quant_unpack
// Receive-side counterpart of the 2-bit sample quantizer. Takes 32-bit words
// holding 16 two-bit codes and emits one decoded signed sample per accepted
// output beat, sample 0 (bits [1:0]) first. A new word is loaded on the same
// edge that consumes the last sample of the current one, so a continuous
// stream runs at one sample per clock.
//
// Code map: 01 -> +MAG_HI, 00 -> +MAG_LO, 11 -> -MAG_LO, 10 -> -MAG_HI
//
// Optional feature (macro QUANT_UNPACK_STATS_EN): per-window counts of
// outer codes and positive codes over 2^WIN_LOG2 accepted samples. Without
// the macro the stat_* outputs are tied to zero and no counters exist.
//
// Ports:
//   clk    - sample clock, all state on the rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - quant_unpack_if.slave (word in, sample out, statistics)
//
// Parameters:
//   MAG_LO   - magnitude of inner codes (7-bit, less than MAG_HI)
//   MAG_HI   - magnitude of outer codes (7-bit)
//   WIN_LOG2 - statistics window length exponent (4..24)
// ---------------------------------------------------------------------------
module quant_unpack #(
    parameter logic [6:0] MAG_LO   = 7'd1,
    parameter logic [6:0] MAG_HI   = 7'd3,
    parameter int         WIN_LOG2 = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    quant_unpack_if.slave bus
);

    logic [31:0] sh;
    logic [3:0]  idx;
    logic        full;
    logic        take_y;
    logic        take_in;

    function automatic logic [7:0] decode(input logic [1:0] code);
        logic [7:0] v;
        case (code)
            2'b01:   v = {1'b0, MAG_HI};
            2'b00:   v = {1'b0, MAG_LO};
            2'b11:   v = -{1'b0, MAG_LO};
            default: v = -{1'b0, MAG_HI};
        endcase
        return v;
    endfunction

    assign take_y  = full && bus.y_ready;
    // The only y_ready -> in_ready path: the buffer frees up exactly when
    // its last sample leaves, which lets the next word slide in bubble-free.
    assign bus.in_ready = !full || (bus.y_ready && idx == 4'd15);
    assign take_in      = bus.in_valid && bus.in_ready;

    // Outputs come from the shift register only. y_val is forced to zero
    // while idle so the reset/empty state reads as a clean zero sample.
    assign bus.y_valid = full;
    assign bus.y_code  = sh[1:0];
    assign bus.y_val   = full ? decode(sh[1:0]) : 8'd0;

    // A mid-word accept shifts; a load happens either into an empty buffer
    // or on the last-sample accept; a last-sample accept with no word
    // waiting empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh   <= '0;
            idx  <= '0;
            full <= 1'b0;
        end else if (take_y && idx != 4'd15) begin
            sh  <= sh >> 2;
            idx <= idx + 4'd1;
        end else if (take_in) begin
            sh   <= bus.in_data;
            idx  <= '0;
            full <= 1'b1;
        end else if (take_y) begin
            sh   <= sh >> 2;
            idx  <= '0;
            full <= 1'b0;
        end
    end

`ifdef QUANT_UNPACK_STATS_EN
    localparam int SW = WIN_LOG2 + 1;

    logic [WIN_LOG2-1:0] wcnt;
    logic [SW-1:0]       ocnt;
    logic [SW-1:0]       pcnt;
    logic [SW-1:0]       stat_outer_r;
    logic [SW-1:0]       stat_pos_r;
    logic                stat_valid_r;
    logic                is_outer;
    logic                is_pos;

    // Outer codes are 01/10 (bits differ); positive codes are 01/00.
    assign is_outer = sh[1] ^ sh[0];
    assign is_pos   = ~sh[1];

    // The wrapping accept folds its own sample into the published totals
    // and restarts the running counts from zero for the next window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt         <= '0;
            ocnt         <= '0;
            pcnt         <= '0;
            stat_outer_r <= '0;
            stat_pos_r   <= '0;
            stat_valid_r <= 1'b0;
        end else begin
            stat_valid_r <= 1'b0;
            if (take_y) begin
                wcnt <= wcnt + 1'b1;
                if (&wcnt) begin
                    stat_outer_r <= ocnt + SW'(is_outer);
                    stat_pos_r   <= pcnt + SW'(is_pos);
                    stat_valid_r <= 1'b1;
                    ocnt         <= '0;
                    pcnt         <= '0;
                end else begin
                    ocnt <= ocnt + SW'(is_outer);
                    pcnt <= pcnt + SW'(is_pos);
                end
            end
        end
    end

    assign bus.stat_outer = stat_outer_r;
    assign bus.stat_pos   = stat_pos_r;
    assign bus.stat_valid = stat_valid_r;
`else
    assign bus.stat_outer = '0;
    assign bus.stat_pos   = '0;
    assign bus.stat_valid = 1'b0;
`endif

endmodule

// File: tb/tb_quant_unpack.sv
// ---------------------------------------------------------------------------
// tb_quant_unpack
// Self-checking bench for quant_unpack with MAG_LO=1, MAG_HI=3, WIN_LOG2=4.
// A table of words with hand-computed decoded sample sequences and window
// statistics is streamed one word at a time; hand-written sequences cover
// back-to-back words, output backpressure and reset in the middle of a word.
// Statistics expectations follow QUANT_UNPACK_STATS_EN (zero when undefined).
// ---------------------------------------------------------------------------
module tb_quant_unpack;

`ifdef QUANT_UNPACK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst_n;

    quant_unpack_if #(.WIN_LOG2(4)) bus ();

    quant_unpack #(
        .MAG_LO  (7'd1),
        .MAG_HI  (7'd3),
        .WIN_LOG2(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  word;
        logic [127:0] vals;   // byte k = expected y_val of sample k
        logic [4:0]   outer;
        logic [4:0]   pos;
    } vec_t;

    vec_t vecs [6];
    int   n_cmp;
    int   n_bad;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Presents a word into an empty buffer and returns at the falling edge
    // after it was loaded, with in_valid dropped and y_ready high.
    task automatic apply_stimulus(input logic [31:0] word);
        bus.in_data  = word;
        bus.in_valid = 1'b1;
        bus.y_ready  = 1'b1;
        #1;
        check_output("in_ready_empty", bus.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int cyc;
        logic rdy;
        logic [7:0] exp_v;

        n_cmp = 0;
        n_bad = 0;

        vecs[0] = '{word: 32'h00000000, vals: 128'h01010101_01010101_01010101_01010101, outer: 5'd0,  pos: 5'd16};
        vecs[1] = '{word: 32'hE4E4E4E4, vals: 128'hFFFD0301_FFFD0301_FFFD0301_FFFD0301, outer: 5'd8,  pos: 5'd8};
        vecs[2] = '{word: 32'h55555555, vals: 128'h03030303_03030303_03030303_03030303, outer: 5'd16, pos: 5'd16};
        vecs[3] = '{word: 32'hFFFFFFFF, vals: 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, outer: 5'd0,  pos: 5'd0};
        vecs[4] = '{word: 32'hAAAAAAAA, vals: 128'hFDFDFDFD_FDFDFDFD_FDFDFDFD_FDFDFDFD, outer: 5'd16, pos: 5'd0};
        vecs[5] = '{word: 32'h1B1B1B1B, vals: 128'h0103FDFF_0103FDFF_0103FDFF_0103FDFF, outer: 5'd8,  pos: 5'd8};

        // reset state
        rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.y_ready  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_output("rst_y_valid", bus.y_valid, 0);
        check_output("rst_y_code", bus.y_code, 0);
        check_output("rst_y_val", bus.y_val, 0);
        check_output("rst_in_ready", bus.in_ready, 1);
        check_output("rst_stat_outer", bus.stat_outer, 0);
        check_output("rst_stat_pos", bus.stat_pos, 0);
        check_output("rst_stat_valid", bus.stat_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // table: one word per window, full-rate output
        for (int v = 0; v < 6; v++) begin
            apply_stimulus(vecs[v].word);
            for (int k = 0; k < 16; k++) begin
                #1;
                check_output("tbl_y_valid", bus.y_valid, 1);
                check_output("tbl_y_code", bus.y_code, vecs[v].word[2*k +: 2]);
                check_output("tbl_y_val", bus.y_val, vecs[v].vals[8*k +: 8]);
                check_output("tbl_in_ready", bus.in_ready, (k == 15));
                @(negedge clk);
            end
            #1;
            check_output("tbl_drained_y_valid", bus.y_valid, 0);
            check_output("tbl_drained_in_ready", bus.in_ready, 1);
            check_output("tbl_stat_valid", bus.stat_valid, STATS);
            check_output("tbl_stat_outer", bus.stat_outer, STATS ? vecs[v].outer : 5'd0);
            check_output("tbl_stat_pos", bus.stat_pos, STATS ? vecs[v].pos : 5'd0);
            @(negedge clk);
            #1;
            check_output("tbl_stat_valid_drop", bus.stat_valid, 0);
        end

        // back-to-back words: 32 samples, no gap
        bus.in_data  = 32'hE4E4E4E4;
        bus.in_valid = 1'b1;
        bus.y_ready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_data = 32'h00000000;
        for (int k = 0; k < 32; k++) begin
            #1;
            exp_v = (k < 16) ? vecs[1].vals[8*k +: 8] : 8'h01;
            check_output("b2b_y_valid", bus.y_valid, 1);
            check_output("b2b_y_val", bus.y_val, exp_v);
            check_output("b2b_in_ready", bus.in_ready, (k % 16 == 15));
            @(negedge clk);
            if (k == 15) bus.in_valid = 1'b0;
        end
        #1;
        check_output("b2b_end_y_valid", bus.y_valid, 0);
        @(negedge clk);

        // backpressure: y_ready 1,0,0 repeating
        apply_stimulus(32'hE4E4E4E4);
        bus.in_data  = 32'h55555555;
        bus.in_valid = 1'b1;
        acc = 0;
        cyc = 0;
        while (acc < 16 && cyc < 100) begin
            bus.y_ready = (cyc % 3 == 0);
            #1;
            check_output("bp_y_valid", bus.y_valid, 1);
            check_output("bp_y_val", bus.y_val, vecs[1].vals[8*acc +: 8]);
            check_output("bp_y_code", bus.y_code, vecs[1].word[2*acc +: 2]);
            check_output("bp_in_ready", bus.in_ready, (bus.y_ready && acc == 15));
            rdy = bus.y_ready;
            @(posedge clk);
            if (rdy) acc++;
            @(negedge clk);
            cyc++;
            if (acc == 15) bus.in_valid = 1'b0;
        end
        check_output("bp_accept_count", acc, 16);
        #1;
        check_output("bp_end_y_valid", bus.y_valid, 0);
        @(negedge clk);

        // reset after 5 accepts of a word
        apply_stimulus(32'hE4E4E4E4);
        repeat (5) @(negedge clk);
        #1;
        check_output("pre_rst_y_val", bus.y_val, vecs[1].vals[8*5 +: 8]);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_y_valid", bus.y_valid, 0);
        check_output("mid_rst_in_ready", bus.in_ready, 1);
        check_output("mid_rst_y_code", bus.y_code, 0);
        check_output("mid_rst_y_val", bus.y_val, 0);
        check_output("mid_rst_stat_outer", bus.stat_outer, 0);
        check_output("mid_rst_stat_pos", bus.stat_pos, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        apply_stimulus(32'h00000001);
        #1;
        check_output("post_rst_s0_code", bus.y_code, 2'b01);
        check_output("post_rst_s0_val", bus.y_val, 8'h03);
        @(negedge clk);
        #1;
        check_output("post_rst_s1_code", bus.y_code, 2'b00);
        check_output("post_rst_s1_val", bus.y_val, 8'h01);
        repeat (15) @(negedge clk);
        #1;
        check_output("post_rst_y_valid", bus.y_valid, 0);
        check_output("post_rst_stat_valid", bus.stat_valid, STATS);
        check_output("post_rst_stat_outer", bus.stat_outer, STATS ? 5'd1 : 5'd0);
        check_output("post_rst_stat_pos", bus.stat_pos, STATS ? 5'd16 : 5'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
